// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth digit accumulator: the recoded digit,
// the accumulator FSM states and the digit-count helper.
package booth_pkg;

  typedef struct packed {
    logic neg;
    logic zero;
    logic two;
  } booth_digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } booth_acc_state_e;

  // One radix-4 digit covers two multiplier bits.
  function automatic int unsigned booth_digits(int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Decodes one Booth digit against the multiplicand into a sign-extended partial product.
// BOOTH_DIGIT_CHECK_EN: when defined, flags zero&two as an illegal digit.
module booth_pp_select
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  booth_digit_t           digit,
  input  logic [WIDTH-1:0]       a,
  output logic [2*WIDTH-1:0]     pp,
  output logic                   illegal
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] mag;

  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    if (digit.zero) begin
      mag = '0;
    end else if (digit.two) begin
      mag = a_ext << 1;
    end else begin
      mag = a_ext;
    end
    // -0 naturally collapses to 0 in two's complement.
    pp = digit.neg ? ('0 - mag) : mag;
  end

`ifdef BOOTH_DIGIT_CHECK_EN
  assign illegal = digit.zero & digit.two;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/booth_digit_accumulator.sv
// Accumulates an LSB-first stream of radix-4 Booth digits into the signed product with a
// multiplicand latched at start; valid/ready on start, digit and result sides.
module booth_digit_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 digit_valid,
  output logic                 digit_ready,
  input  logic                 digit_neg,
  input  logic                 digit_zero,
  input  logic                 digit_two,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int unsigned DIGITS = booth_digits(WIDTH);
  localparam int unsigned CntW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  booth_acc_state_e   state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               err_q, err_d;

  booth_digit_t       digit;
  logic [2*WIDTH-1:0] pp;
  logic               illegal;
  logic [CntW:0]      shamt;

  assign digit = '{neg: digit_neg, zero: digit_zero, two: digit_two};
  assign shamt = {cnt_q, 1'b0};

  booth_pp_select #(
    .WIDTH (WIDTH)
  ) u_pp_select (
    .digit   (digit),
    .a       (a_q),
    .pp      (pp),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    err_d   = err_q;

    // Readies are pure state decode so they never depend on incoming valids.
    start_ready  = (state_q == StIdle);
    digit_ready  = (state_q == StAccum);
    result_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = multiplicand;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (digit_valid) begin
          acc_d = acc_q + (pp << shamt);
          cnt_d = cnt_q + CntW'(1);
          if (illegal) begin
            err_d = 1'b1;
          end
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // acc is only cleared on start, so the product holds through IDLE.
  assign result = acc_q;
  assign err    = err_q;

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// Randomised self-checking bench for booth_digit_accumulator (WIDTH=8) against an A*B reference.
module tb_booth_digit_accumulator;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int          Bound  = 200;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic                 digit_valid;
  logic                 digit_ready;
  logic                 digit_neg;
  logic                 digit_zero;
  logic                 digit_two;
  logic                 result_valid;
  logic                 result_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_digit_accumulator #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .multiplicand (multiplicand),
    .digit_valid  (digit_valid),
    .digit_ready  (digit_ready),
    .digit_neg    (digit_neg),
    .digit_zero   (digit_zero),
    .digit_two    (digit_two),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Radix-4 Booth digit i of b as a signed value in -2..2.
  function automatic int booth_val(input logic [WIDTH-1:0] b, input int i);
    int lo;
    lo = (i == 0) ? 0 : int'(b[2*i-1]);
    return -2 * int'(b[2*i+1]) + int'(b[2*i]) + lo;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a);
    int n;
    start_valid  = 1'b1;
    multiplicand = a;
    n = 0;
    while (!start_ready && n < Bound) begin
      step();
      n++;
    end
    if (!start_ready) check("start_timeout", 32'(start_ready), 32'd1);
    step();
    start_valid  = 1'b0;
    multiplicand = $urandom();
  endtask

  // Sends one digit given as {neg,zero,two}, optionally preceded by bubbles.
  task automatic send_digit(input logic [2:0] d, input int bubbles);
    int n;
    digit_valid = 1'b0;
    for (int k = 0; k < bubbles; k++) begin
      {digit_neg, digit_zero, digit_two} = 3'($urandom());
      step();
    end
    {digit_neg, digit_zero, digit_two} = d;
    digit_valid = 1'b1;
    n = 0;
    while (!digit_ready && n < Bound) begin
      step();
      n++;
    end
    if (!digit_ready) check("digit_timeout", 32'(digit_ready), 32'd1);
    step();
    digit_valid = 1'b0;
  endtask

  function automatic logic [2:0] enc(input int v, input logic neg_zero);
    logic [2:0] r;
    if (v == 0) r = {neg_zero, 1'b1, 1'b0};
    else r = {(v < 0), 1'b0, (v == 2 || v == -2)};
    return r;
  endfunction

  task automatic send_operand(input logic [WIDTH-1:0] b, input int max_bubbles);
    for (int i = 0; i < DIGITS; i++) begin
      send_digit(enc(booth_val(b, i), 1'($urandom())),
                 (max_bubbles > 0) ? int'($urandom_range(max_bubbles)) : 0);
    end
  endtask

  task automatic accept_result();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("rv_drop", 32'(result_valid), 32'd0);
  endtask

  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] exp_r;
  logic [2*WIDTH-1:0] held;
  logic               err_exp;

  initial begin
    rst          = 1'b0;
    start_valid  = 1'b0;
    multiplicand = '0;
    digit_valid  = 1'b0;
    {digit_neg, digit_zero, digit_two} = 3'b000;
    result_ready = 1'b0;
    do_reset();

    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_digit_ready", 32'(digit_ready), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // A=7, B=3 directed, no bubbles: result_valid right after the fourth beat.
    start_op(8'd7);
    check("accum_start_ready", 32'(start_ready), 32'd0);
    check("accum_digit_ready", 32'(digit_ready), 32'd1);
    send_digit(3'b100, 0);
    send_digit(3'b000, 0);
    check("mid_rv", 32'(result_valid), 32'd0);
    send_digit(3'b010, 0);
    send_digit(3'b010, 0);
    check("a7_rv", 32'(result_valid), 32'd1);
    check("a7_result", 32'(result), 32'h0015);
    check("a7_err", 32'(err), 32'd0);
    // Hold result_ready low in DONE: everything must stay put.
    held = result;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_rv", 32'(result_valid), 32'd1);
      check("stall_result", 32'(result), 32'(held));
      check("stall_start_ready", 32'(start_ready), 32'd0);
      check("stall_digit_ready", 32'(digit_ready), 32'd0);
    end
    accept_result();
    check("idle_hold_result", 32'(result), 32'h0015);

    // A=-128, B=-128.
    start_op(8'h80);
    send_digit(3'b010, 0);
    send_digit(3'b010, 0);
    send_digit(3'b110, 0);
    send_digit(3'b101, 0);
    check("min_result", 32'(result), 32'h4000);
    accept_result();

    // Illegal {zero,two} digit accumulates as 0; err depends on the build.
`ifdef BOOTH_DIGIT_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    start_op(8'd9);
    send_digit(3'b011, 0);
    check("illegal_err_now", 32'(err), 32'(err_exp));
    send_digit(3'b000, 0);
    send_digit(3'b010, 0);
    send_digit(3'b010, 0);
    check("illegal_result", 32'(result), 32'h0009 << 2);
    check("illegal_err_done", 32'(err), 32'(err_exp));
    accept_result();
    check("illegal_err_idle", 32'(err), 32'(err_exp));
    start_op(8'd1);
    check("err_clr_on_start", 32'(err), 32'd0);

    // Reset mid-accumulation after two digits.
    send_digit(3'b000, 0);
    send_digit(3'b000, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_start_ready", 32'(start_ready), 32'd1);
    check("midrst_digit_ready", 32'(digit_ready), 32'd0);
    check("midrst_rv", 32'(result_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    start_op(8'd5);
    send_operand(8'hFD, 0);
    check("a5_bm3_result", 32'(result), 32'hFFF1);
    accept_result();

    // Random operands with bubbles on the digit side and on result acceptance.
    for (int op = 0; op < 1000; op++) begin
      a_r = WIDTH'($urandom());
      b_r = WIDTH'($urandom());
      exp_r = 16'(int'($signed(a_r)) * int'($signed(b_r)));
      start_op(a_r);
      send_operand(b_r, 3);
      check("rnd_rv", 32'(result_valid), 32'd1);
      for (int k = 0; k < int'($urandom_range(2)); k++) step();
      check("rnd_result", 32'(result), 32'(exp_r));
      accept_result();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
